// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: fixed-latency mult/div, architectural HI/LO,
// mfhi/mflo read port and mthi/mtlo writes, gated by the exception request.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  mdu_ctr,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_out
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [3:0]    op_q, op_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic          accept;
    logic [63:0]   prod_u;
    logic [63:0]   prod_s;
    logic [31:0]   mag_a;
    logic [31:0]   mag_b;
    logic [31:0]   uq;
    logic [31:0]   ur;
    logic [31:0]   sq;
    logic [31:0]   sr;
    logic [31:0]   dq;
    logic [31:0]   dr;

    // Datapath results from the latched operands; consumed only on the commit edge.
    always_comb begin
        prod_u = {32'h0, a_q} * {32'h0, b_q};
        prod_s = 64'($signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q}));
        // Signed divide through magnitudes so -2^31 / -1 wraps cleanly to 32'h80000000.
        mag_a  = a_q[31] ? 32'(-a_q) : a_q;
        mag_b  = b_q[31] ? 32'(-b_q) : b_q;
        uq     = '0;
        ur     = '0;
        dq     = '0;
        dr     = '0;
        if (b_q != 32'h0) begin
            uq = mag_a / mag_b;
            ur = mag_a % mag_b;
            dq = a_q / b_q;
            dr = a_q % b_q;
        end
        sq = (a_q[31] ^ b_q[31]) ? 32'(-uq) : uq;
        sr = a_q[31] ? 32'(-ur) : ur;
    end

    assign accept = start && !req && !busy_q &&
                    (mdu_ctr == OP_MULT || mdu_ctr == OP_MULTU ||
                     mdu_ctr == OP_DIV  || mdu_ctr == OP_DIVU);

    // Next-state: countdown with commit on 1->0, accept when idle, mt* writes when idle.
    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        hi_d  = hi_q;
        lo_d  = lo_q;

        if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                case (op_q)
                    OP_MULT: begin
                        hi_d = prod_s[63:32];
                        lo_d = prod_s[31:0];
                    end
                    OP_MULTU: begin
                        hi_d = prod_u[63:32];
                        lo_d = prod_u[31:0];
                    end
                    OP_DIV: begin
                        if (b_q != 32'h0) begin
                            hi_d = sr;
                            lo_d = sq;
                        end
                    end
                    OP_DIVU: begin
                        if (b_q != 32'h0) begin
                            hi_d = dr;
                            lo_d = dq;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (accept) begin
            op_d  = mdu_ctr;
            a_d   = rs;
            b_d   = rt;
            cnt_d = (mdu_ctr == OP_MULT || mdu_ctr == OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end else if (!req) begin
            if (mdu_ctr == OP_MTHI) hi_d = rs;
            if (mdu_ctr == OP_MTLO) lo_d = rs;
        end

        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Read port sees registered HI/LO only; no bypass of an in-flight result.
    always_comb begin
        mdu_out = 32'h0;
        if (mdu_ctr == OP_MFHI) mdu_out = hi_q;
        if (mdu_ctr == OP_MFLO) mdu_out = lo_q;
    end

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed vector table, hand-written corner sequences, and
// random ops checked against a plain-arithmetic HI/LO model.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        start;
    logic [3:0]  ctr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_out;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .req(req), .start(start), .mdu_ctr(ctr),
        .rs(rs), .rt(rt), .busy(busy), .hi(hi), .lo(lo), .mdu_out(mdu_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: HI/LO after an op, from the arithmetic definitions.
    task automatic model_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (c)
            4'd1: begin
                p = 64'(sa * sb);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            4'd2: begin
                p = {32'h0, a} * {32'h0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            4'd3: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            4'd4: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            default: ;
        endcase
    endtask

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; ctr = c; rs = a; rt = b;
        @(negedge clk);
        start = 1'b0; ctr = 4'd0; rs = '0; rt = '0;
    endtask

    // Counts busy cycles seen at negedges, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b);
        int n;
        issue(c, a, b);
        wait_idle(n);
        model_op(c, a, b);
        check({name, " busy_cycles"}, 32'(n), (c <= 4'd2) ? 32'd5 : 32'd10);
        check({name, " hi"}, hi, m_hi);
        check({name, " lo"}, lo, m_lo);
    endtask

    vec_t vecs[8];

    initial begin
        int n;
        vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,          32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'd2,          32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{4'd4, 32'd7,        32'd0,          32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF,   32'h00000000, 32'h80000000, 10};
        vecs[5] = '{4'd4, 32'd7,        32'd2,          32'h00000001, 32'h00000003, 10};
        vecs[6] = '{4'd3, 32'd7,        32'hFFFFFFFE,   32'h00000001, 32'hFFFFFFFD, 10};
        vecs[7] = '{4'd3, 32'd5,        32'd0,          32'h00000001, 32'hFFFFFFFD, 10};

        reset = 1'b1; req = 1'b0; start = 1'b0; ctr = '0; rs = '0; rt = '0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].c, vecs[i].a, vecs[i].b);
            wait_idle(n);
            check($sformatf("vec%0d busy_cycles", i), 32'(n), 32'(vecs[i].cyc));
            check($sformatf("vec%0d hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d lo", i), lo, vecs[i].lo);
        end
        m_hi = 32'h00000001;
        m_lo = 32'hFFFFFFFD;

        // mflo/mfhi read path and idle output
        ctr = 4'd5; #1 check("mfhi", mdu_out, m_hi);
        ctr = 4'd6; #1 check("mflo", mdu_out, m_lo);
        ctr = 4'd0; #1 check("mdu_out idle", mdu_out, 32'h0);

        // start with req: cancelled
        @(negedge clk);
        start = 1'b1; ctr = 4'd1; rs = 32'd9; rt = 32'd9; req = 1'b1;
        @(negedge clk);
        start = 1'b0; ctr = 4'd0; req = 1'b0;
        check("req start busy", {31'h0, busy}, 32'h0);
        repeat (6) @(negedge clk);
        check("req start hi", hi, m_hi);
        check("req start lo", lo, m_lo);

        // mthi with req: ignored
        ctr = 4'd7; rs = 32'h1234; req = 1'b1;
        @(negedge clk);
        ctr = 4'd0; req = 1'b0;
        check("mthi req hi", hi, m_hi);

        // mtlo then mflo next cycle
        ctr = 4'd8; rs = 32'hABCD;
        @(negedge clk);
        ctr = 4'd6; rs = '0;
        #1 check("mtlo then mflo", mdu_out, 32'hABCD);
        m_lo = 32'hABCD;
        ctr = 4'd7; rs = 32'h5555;
        @(negedge clk);
        ctr = 4'd0;
        check("mthi hi", hi, 32'h5555);
        m_hi = 32'h5555;

        // mthi and a second start while busy: both ignored, original mult commits
        issue(4'd1, 32'd6, 32'd7);
        ctr = 4'd7; rs = 32'hDEAD;
        @(negedge clk);
        ctr = 4'd3; start = 1'b1; rs = 32'd100; rt = 32'd3;
        @(negedge clk);
        ctr = 4'd0; start = 1'b0;
        wait_idle(n);
        check("busy-gated busy_cycles", 32'(n + 2), 32'd5);
        check("busy-gated hi", hi, 32'h0);
        check("busy-gated lo", lo, 32'd42);
        m_hi = 32'h0; m_lo = 32'd42;

        // req during an accepted op does not abort it
        issue(4'd2, 32'd1000, 32'd1000);
        req = 1'b1;
        wait_idle(n);
        req = 1'b0;
        check("req midop busy_cycles", 32'(n), 32'd5);
        check("req midop lo", lo, 32'd1000000);
        m_lo = 32'd1000000;

        // random ops against the model
        for (int k = 0; k < 30; k++) begin
            logic [3:0]  c;
            logic [31:0] a;
            logic [31:0] b;
            c = 4'($urandom_range(1, 4));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 9));
                2: b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            run_op($sformatf("rand%0d", k), c, a, b);
        end

        // async reset mid divide: immediate clear, no late commit
        ctr = 4'd7; rs = 32'hCAFE;
        @(negedge clk);
        ctr = 4'd0;
        issue(4'd4, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        check("pre-reset busy", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        #1;
        check("reset midop busy", {31'h0, busy}, 32'h0);
        check("reset midop hi", hi, 32'h0);
        check("reset midop lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("post-reset busy", {31'h0, busy}, 32'h0);
        check("post-reset hi", hi, 32'h0);
        check("post-reset lo", lo, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
